// File: rtl/alu_pkg.sv
// Shared types for the byte-serial bitwise ALU front end: opcode and sequencer state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NAND  = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_e;

  // A single-byte operand still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/alu_logic16.sv
// Purely combinational bitwise function unit selected by a 3-bit opcode.
module alu_logic16
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          opcode,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_NAND:  result = ~(a & b);
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_NOR:   result = ~(a | b);
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_NOTA:  result = ~a;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_sequencer.sv
// Byte-serial request/response sequencer: collects opcode, A and B bytes, executes one
// bitwise operation and streams the W-bit result back LSB-first.
module alu_logic_sequencer
#(
  parameter int unsigned W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       zero,
  output logic       busy
);

  import alu_pkg::*;

  localparam int unsigned NB = W / 8;
  localparam int unsigned IW = idx_width(NB);
  localparam logic [IW-1:0] LastIdx = IW'(NB - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  op_e            op_q;
  logic [W-1:0]   a_q, b_q, result_q;
  logic           zero_q;
  logic [W-1:0]   f_result;

  logic latch_op, load_a, load_b, exec;

  alu_logic16 #(
    .W(W)
  ) u_logic (
    .a      (a_q),
    .b      (b_q),
    .opcode (op_q),
    .result (f_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs depend on registered state only; handshake inputs feed next-state alone.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b1;
    latch_op  = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    exec      = 1'b0;
    case (state_q)
      S_OP: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          latch_op = 1'b1;
          idx_d    = '0;
          state_d  = S_A;
        end
      end
      S_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_a = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = S_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_b = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = S_EXEC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        exec    = 1'b1;
        idx_d   = '0;
        state_d = S_RES;
      end
      S_RES: begin
        out_valid = 1'b1;
        out_data  = result_q[8*idx_q +: 8];
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = S_OP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_OP;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_NAND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (latch_op) op_q <= op_e'(in_data[2:0]);
      if (load_a)   a_q[8*idx_q +: 8] <= in_data;
      if (load_b)   b_q[8*idx_q +: 8] <= in_data;
      if (exec) begin
        result_q <= f_result;
        zero_q   <= (f_result == '0);
      end
    end
  end

  assign zero = zero_q;

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Randomised self-checking bench for alu_logic_sequencer against a truth-table reference model.
module tb_alu_logic_sequencer;

  localparam int W  = 16;
  localparam int NB = W / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       zero;
  logic       busy;

  int total = 0;
  int bad   = 0;

  alu_logic_sequencer #(
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Per-bit truth table of each function, indexed by {a_bit, b_bit}.
  function automatic logic [3:0] truth(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b0111;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1110;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input logic [7:0] opb, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    tt = truth(opb[2:0]);
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_wait got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] d);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL out_valid_wait got=%b want=1", out_valid);
    end
    out_ready = 1'b1;
    d = out_data;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_request(input logic [7:0] opb, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit gap, output logic [W-1:0] res, output logic z,
                            output int lat, output logic busy_end, output logic inrdy_end);
    logic [7:0] d;
    send_byte(opb);
    for (int i = 0; i < NB; i++) begin
      if (gap) begin @(posedge clk); #1; end
      send_byte(a[8*i +: 8]);
    end
    for (int i = 0; i < NB; i++) begin
      if (gap) begin @(posedge clk); #1; end
      send_byte(b[8*i +: 8]);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z = zero;
    for (int i = 0; i < NB; i++) begin
      recv_byte(d);
      res[8*i +: 8] = d;
    end
    busy_end  = busy;
    inrdy_end = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    #2;
    total += 5;
    if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00)  begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    if (zero !== 1'b0)       begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nand();
    logic [W-1:0] res, exp;
    logic z, be, ir;
    int lat;
    exp = model(8'h00, 16'hFFFF, 16'h0F0F);
    do_request(8'h00, 16'hFFFF, 16'h0F0F, 1'b0, res, z, lat, be, ir);
    total += 5;
    if (res !== exp)   begin bad++; $display("FAIL nand_result got=%h want=%h", res, exp); end
    if (z !== 1'b0)    begin bad++; $display("FAIL nand_zero got=%b want=0", z); end
    if (lat !== 1)     begin bad++; $display("FAIL nand_latency got=%0d want=1", lat); end
    if (be !== 1'b0)   begin bad++; $display("FAIL nand_busy_end got=%b want=0", be); end
    if (ir !== 1'b1)   begin bad++; $display("FAIL nand_in_ready_end got=%b want=1", ir); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] res, exp;
    logic z, be, ir;
    int lat;
    exp = model(8'h02, 16'h0100, 16'h0010);
    do_request(8'h02, 16'h0100, 16'h0010, 1'b1, res, z, lat, be, ir);
    total += 3;
    if (res !== exp)        begin bad++; $display("FAIL gaps_result got=%h want=%h", res, exp); end
    if (res !== 16'h0110)   begin bad++; $display("FAIL gaps_result_const got=%h want=0110", res); end
    if (lat !== 1)          begin bad++; $display("FAIL gaps_latency got=%0d want=1", lat); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    logic [7:0]   d0, d1;
    logic         held_ok;
    int           n;
    exp = model(8'h04, 16'h1234, 16'h00FF);
    send_byte(8'h04);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hFF); send_byte(8'h00);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    held_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== exp[7:0] || in_ready !== 1'b0) held_ok = 1'b0;
      @(posedge clk); #1;
    end
    total += 1;
    if (held_ok !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got=%b want=1 (out_data=%h exp=%h)", held_ok, out_data, exp[7:0]);
    end
    recv_byte(d0);
    recv_byte(d1);
    total += 3;
    if (d0 !== exp[7:0])  begin bad++; $display("FAIL bp_byte0 got=%h want=%h", d0, exp[7:0]); end
    if (d1 !== exp[15:8]) begin bad++; $display("FAIL bp_byte1 got=%h want=%h", d1, exp[15:8]); end
    if ({d1, d0} !== 16'h12CB) begin bad++; $display("FAIL bp_const got=%h want=12CB", {d1, d0}); end
  endtask

  task automatic test_and_zero();
    logic [W-1:0] res, exp;
    logic z, be, ir;
    int lat;
    exp = model(8'h01, 16'h55AA, 16'hAA55);
    do_request(8'h01, 16'h55AA, 16'hAA55, 1'b0, res, z, lat, be, ir);
    total += 2;
    if (res !== exp)  begin bad++; $display("FAIL and_result got=%h want=%h", res, exp); end
    if (z !== (exp == '0)) begin bad++; $display("FAIL and_zero got=%b want=%b", z, exp == '0); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, a;
    logic z, be, ir, quiet;
    int lat;
    send_byte(8'h00);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    total += 5;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL rmid_out_data got=%h want=00", out_data); end
    if (zero !== 1'b0)      begin bad++; $display("FAIL rmid_zero got=%b want=0", zero); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    total += 1;
    if (quiet !== 1'b1) begin bad++; $display("FAIL rmid_quiet got=%b want=1", quiet); end
    a = W'($urandom);
    do_request(8'h07, a, 16'hBEEF, 1'b0, res, z, lat, be, ir);
    total += 1;
    if (res !== 16'hBEEF) begin bad++; $display("FAIL rmid_passb got=%h want=BEEF", res); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, exp, a, b;
    logic z, be, ir;
    int lat;
    a = W'($urandom);
    b = W'($urandom);
    exp = model(8'hF8, a, b);
    do_request(8'hF8, a, b, 1'b0, res, z, lat, be, ir);
    total += 2;
    if (res !== exp)  begin bad++; $display("FAIL b2b_nand got=%h want=%h", res, exp); end
    if (ir !== 1'b1)  begin bad++; $display("FAIL b2b_in_ready got=%b want=1", ir); end
    b = W'($urandom);
    do_request(8'h0E, 16'h00FF, b, 1'b0, res, z, lat, be, ir);
    total += 2;
    if (res !== 16'hFF00) begin bad++; $display("FAIL b2b_nota got=%h want=FF00", res); end
    if (lat !== 1)        begin bad++; $display("FAIL b2b_latency got=%0d want=1", lat); end
  endtask

  task automatic test_random();
    logic [W-1:0] res, exp, a, b;
    logic [7:0]   opb;
    logic z, be, ir;
    int lat;
    for (int i = 0; i < 24; i++) begin
      opb = 8'($urandom);
      a   = W'($urandom);
      b   = (i % 6 == 0) ? a : W'($urandom);
      exp = model(opb, a, b);
      do_request(opb, a, b, bit'($urandom_range(0, 1)), res, z, lat, be, ir);
      total += 3;
      if (res !== exp) begin
        bad++;
        $display("FAIL rand_result op=%h a=%h b=%h got=%h want=%h", opb, a, b, res, exp);
      end
      if (z !== (exp == '0)) begin
        bad++;
        $display("FAIL rand_zero op=%h got=%b want=%b", opb, z, exp == '0);
      end
      if (lat !== 1) begin bad++; $display("FAIL rand_latency got=%0d want=1", lat); end
    end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_gaps();
    test_backpressure();
    test_and_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_logic_sequencer.md
# alu_logic_sequencer

Byte-serial front end for the 16-bit bitwise logic unit of the ALU. It receives an opcode and two operands as a byte stream from the MCU-side bus and drives A and B into the bitwise unit. It captures the 16-bit result, computes a zero flag, and streams the result back a byte at a time. Both byte streams use valid/ready handshakes. The block sits between the MCU data bus and the ALU bitwise datapath.

## Interface
Parameters:
- `W`, default 16: operand/result width. Must be a multiple of 8 and ≥ 8. Bytes per operand: NB = W/8.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream byte valid
- `in_ready`  out  1  block can accept a byte
- `in_data`  in  8  request byte: opcode, then A LSB-first, then B LSB-first
- `out_valid`  out  1  result byte valid
- `out_ready`  in  1  downstream accepts result byte
- `out_data`  out  8  result byte, LSB-first
- `zero`  out  1  last result == 0; held until next result
- `busy`  out  1  high from opcode accept until last result byte accepted

## Operation
- **Opcode byte:** bits [2:0] select the function; bits [7:3] are ignored.
  - 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS B.
- **States:** `S_OP` → `S_A` → `S_B` → `S_EXEC` → `S_RES` → `S_OP`.
- **Byte transfer:** a byte transfers on a rising edge with `in_valid && in_ready`.
- **`S_OP`:**
  - `in_ready`=1.
  - On transfer: latch the opcode, clear the byte index, go to `S_A`.
- **`S_A`:**
  - `in_ready`=1.
  - Each transfer writes `A[8*idx +: 8]`.
  - On byte NB-1: clear the index, go to `S_B`.
- **`S_B`:**
  - Same as `S_A`, writing B.
  - On byte NB-1: go to `S_EXEC`.
- **`S_EXEC`:**
  - `in_ready`=0.
  - One cycle. Register `result` = f(A, B) and `zero` = (f(A, B) == 0). Clear the index, go to `S_RES`.
- **`S_RES`:**
  - `out_valid`=1 and `out_data` = `result[8*idx +: 8]`.
  - Advance the index on `out_valid && out_ready`.
  - On byte NB-1 accepted: go to `S_OP`.
- **Input gaps:** `in_valid` low in any load state holds state and index indefinitely.
- **Output backpressure:** `out_ready` low holds `out_data` and `out_valid` stable.
- **No overlap:** `in_ready` is 0 during `S_EXEC` and `S_RES`. A new request cannot start until the result has fully drained.
- **`busy`:** 1 in `S_A`, `S_B`, `S_EXEC`, `S_RES`; 0 in `S_OP`.
- **Reset (any time, including mid-request or mid-result):**
  - State returns to `S_OP`. A, B, result, index and opcode all clear to 0.
  - Partial data is discarded; no partial output is produced after reset.
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_data`=0x00, `zero`=0, `busy`=0.

## Timing
- `in_ready`, `out_valid`, `out_data` and `busy` are decoded from registered state, index and result only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Latency:**
  - Last B byte accepted at edge N.
  - `S_EXEC` during cycle N..N+1.
  - `out_valid` high from edge N+1, with `zero` already valid.
- **Minimum request cost:** 2·NB+1 input cycles + 1 exec cycle + NB output cycles. For W=16 this is 8 cycles.
- After the final result byte is accepted at edge M, `in_ready`=1 from edge M.

## Structure
- **Shared package `alu_pkg`:**
  - opcode enum (`OP_NAND` … `OP_PASSB`, 3 bits)
  - sequencer state enum (`S_OP`, `S_A`, `S_B`, `S_EXEC`, `S_RES`)
- **Sub-module `alu_logic16`:** purely combinational bitwise function unit.
  - Ports: A, B, opcode, result (width `W`).
  - Instantiated once, fed from the A/B/opcode registers.
- The sequencer holds the FSM, byte index (width clog2(NB), min 1), operand/result registers and flags.

## Test plan
- **NAND:** send 00, FF, FF, 0F, 0F with `out_ready`=1 → `out_data` F0 then F0, `zero`=0, `busy` falls after the second byte.
- **AND, zero result:** send 01, AA, 55, 55, AA → result 0x0000, `zero`=1, bytes 00, 00.
- **Output backpressure:** XOR op 04, A=0x1234, B=0x00FF with `out_ready`=0 for 5 cycles → `out_data` held at CB and `in_ready`=0 throughout; then bytes CB, 12.
- **Input gaps:** `in_valid` toggling 1/0 while sending OR op 02, A=0x0100, B=0x0010 → result 0x0110 with latency measured from the last accepted byte (edge N+1 `out_valid`).
- **Reset mid-operation:** assert `rst_n` low after the A bytes of a NAND request → all outputs at reset values; then a fresh PASS B (07, A=xx, B=0xBEEF) returns EF, BE.
- **Back-to-back with ignored opcode bits:** opcode F8 (NAND) then 0E (NOT A, A=0x00FF) → results 0xFFFF-style NAND output, then FF-inverted bytes 00, FF. `in_ready` rises on the same edge the prior final byte is accepted.
